hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 SHALL have parameter STAT_W, default 16, width of the statistics counters.
REQ-002 SHALL have parameter MEM_TO, default 15, the maximum MEM_WAIT cycles before timeout (range 1..255).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port id_rs_a, id_rs_b, id_rs_c  input  3 each  register selects of the three decode-stage source operands.
REQ-006 SHALL have port id_src_vld  input  3  per-operand valid (bit0=a, bit1=b, bit2=c).
REQ-007 SHALL have port idex_memread  input  1  the slot-1 instruction in ID/EX is a load.
REQ-008 SHALL have port idex_rd1  input  3  destination of the slot-1 instruction in ID/EX.
REQ-009 SHALL have port br_taken  input  1  a branch resolved taken in EX.
REQ-010 SHALL have port mem_req, mem_ack  input  1 each  data-memory access pending in MEM / access complete.
REQ-011 SHALL have port pc_write, ifid_write  output  1 each  PC and IF/ID register update enables.
REQ-012 SHALL have port idex_bubble, ifid_flush, exmem_hold  output  1 each  ID/EX NOP insert / IF/ID clear / EX/MEM and MEM/WB freeze.
REQ-013 SHALL have port mem_timeout  output  1  sticky timeout error.
REQ-014 SHALL have ports stall_cnt, flush_cnt  output  STAT_W each  statistics counters.

Function
REQ-015 SHALL implement FSM states RUN, LOAD_STALL, FLUSH, MEM_WAIT; state is registered and outputs are combinational from state and current inputs.
REQ-016 Default outputs (no event) SHALL be pc_write=1, ifid_write=1, idex_bubble=0, ifid_flush=0, exmem_hold=0.
REQ-017 Event priority SHALL be: memory wait > branch flush > load-use.
REQ-018 Memory wait in RUN, LOAD_STALL or FLUSH: if mem_req=1 and mem_ack=0, then pc_write=0, ifid_write=0, exmem_hold=1, and next state is MEM_WAIT; mem_req with mem_ack in the same cycle SHALL cause no stall.
REQ-019 MEM_WAIT: the freeze outputs SHALL be held while mem_ack=0; in the cycle mem_ack=1, freeze SHALL deassert and next state is RUN.
REQ-020 MEM_WAIT timeout: a wait counter SHALL be cleared on entry; when it reaches MEM_TO with no ack, mem_timeout SHALL be set (sticky until reset), freeze SHALL be released that cycle, and next state is RUN.
REQ-021 Branch in RUN or LOAD_STALL: br_taken=1 SHALL give ifid_flush=1 and idex_bubble=1 with pc_write=1, and next state is FLUSH.
REQ-022 FLUSH SHALL assert ifid_flush=1 for exactly one further cycle (two-cycle fetch latency), suppress load-use detection, and then go to RUN; a br_taken in FLUSH SHALL restart FLUSH.
REQ-023 Load-use hazard: in RUN, a hazard exists when idex_memread=1 and any valid source equals idex_rd1.
REQ-024 On a load-use hazard, pc_write=0, ifid_write=0, idex_bubble=1, and next state is LOAD_STALL.
REQ-025 LOAD_STALL SHALL behave as RUN with load-use detection masked for exactly one cycle, then go to RUN.
REQ-026 br_taken and mem_req asserted together SHALL enter MEM_WAIT; br_taken held on exit SHALL then flush.

Reset
REQ-027 rst_n=0 SHALL immediately force state RUN and clear the wait counter, mem_timeout, stall_cnt and flush_cnt.
REQ-028 Reset in mid-MEM_WAIT or mid-FLUSH SHALL abandon the operation with no residual output.

Configuration
REQ-029 Macro HAZ_STATS_EN defined: stall_cnt SHALL increment, saturating, on every cycle with pc_write=0, and flush_cnt SHALL increment, saturating, on every cycle with ifid_flush=1.
REQ-030 Macro HAZ_STATS_EN undefined: stall_cnt and flush_cnt SHALL be constant 0, with no counter logic.

Verification
REQ-031 Load r3 in ID/EX (idex_rd1=3, idex_memread=1), id_rs_b=3 valid -> one cycle pc_write=0, idex_bubble=1; next cycle RUN outputs; stall_cnt=1.
REQ-032 Same match with id_src_vld=0 -> no stall.
REQ-033 br_taken pulse -> ifid_flush=1 for 2 cycles and idex_bubble=1 in the first; flush_cnt=2.
REQ-034 mem_req=1 with mem_ack arriving after 4 cycles -> exmem_hold=1 for 4 cycles, released in the ack cycle; stall_cnt=4.
REQ-035 mem_req=1 with no ack, MEM_TO=15 -> mem_timeout=1 after 15 wait cycles and stays 1; return to RUN.
REQ-036 rst_n low during MEM_WAIT -> all outputs at defaults and counters 0 immediately, with no clock edge.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl_if
// Purpose : bundles the pipeline-side signals of the hazard/stall controller.
// Ports (signals):
//   decode operands : id_rs_a/b/c [2:0], id_src_vld [2:0] (bit0=a, bit1=b, bit2=c)
//   ID/EX info      : idex_memread, idex_rd1 [2:0]
//   events          : br_taken, mem_req, mem_ack
//   controls        : pc_write, ifid_write, idex_bubble, ifid_flush, exmem_hold
//   status          : mem_timeout, stall_cnt / flush_cnt [STAT_W-1:0]
// Modports: master = pipeline (drives events, receives controls),
//           slave  = controller.
// Handshake: mem_req is a level held by MEM while an access is pending;
// mem_ack is a one-cycle completion strobe. mem_req with mem_ack high in
// the same cycle is a completed access; mem_req with mem_ack low is a stall.
// ---------------------------------------------------------------------------
interface hazard_stall_ctrl_if #(
    parameter int STAT_W = 16
);
    logic [2:0]        id_rs_a;
    logic [2:0]        id_rs_b;
    logic [2:0]        id_rs_c;
    logic [2:0]        id_src_vld;
    logic              idex_memread;
    logic [2:0]        idex_rd1;
    logic              br_taken;
    logic              mem_req;
    logic              mem_ack;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_bubble;
    logic              ifid_flush;
    logic              exmem_hold;
    logic              mem_timeout;
    logic [STAT_W-1:0] stall_cnt;
    logic [STAT_W-1:0] flush_cnt;

    modport master (
        output id_rs_a, id_rs_b, id_rs_c, id_src_vld, idex_memread, idex_rd1,
        output br_taken, mem_req, mem_ack,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, exmem_hold,
        input  mem_timeout, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_rs_a, id_rs_b, id_rs_c, id_src_vld, idex_memread, idex_rd1,
        input  br_taken, mem_req, mem_ack,
        output pc_write, ifid_write, idex_bubble, ifid_flush, exmem_hold,
        output mem_timeout, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
// Purpose : pipeline hazard controller. Detects load-use hazards, flushes on
//           taken branches (two-cycle fetch latency) and freezes the back end
//           while a data-memory access is pending, with a wait timeout.
//           Priority: memory wait > branch flush > load-use.
// Ports   : clk, rst_n (async, active low)
//           hs        : hazard_stall_ctrl_if.slave (operands, events, controls,
//                       sticky mem_timeout, statistics counters)
//           dbg_state : current FSM state (0 RUN, 1 LOAD_STALL, 2 FLUSH,
//                       3 MEM_WAIT)
// Params  : STAT_W  width of statistics counters
//           MEM_TO  MEM_WAIT cycles without ack before timeout (1..255)
// Config  : define HAZ_STATS_EN to build the saturating stall/flush counters;
//           otherwise both counters are constant zero.
// Timeout : the wait counter is cleared when MEM_WAIT is entered and counts
//           MEM_WAIT cycles without ack; in the MEM_WAIT cycle where it equals
//           MEM_TO the freeze is released, mem_timeout is set (visible from
//           the next cycle) and the FSM returns to RUN.
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int STAT_W = 16,
    parameter int MEM_TO = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    hazard_stall_ctrl_if.slave  hs,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_FLUSH      = 2'd2,
        ST_MEM_WAIT   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;

    logic pc_write, ifid_write, idex_bubble, ifid_flush, exmem_hold;
    logic mem_stall, load_use;

    assign mem_stall = hs.mem_req && !hs.mem_ack;

    assign load_use = hs.idex_memread &&
                      ((hs.id_src_vld[0] && (hs.id_rs_a == hs.idex_rd1)) ||
                       (hs.id_src_vld[1] && (hs.id_rs_b == hs.idex_rd1)) ||
                       (hs.id_src_vld[2] && (hs.id_rs_c == hs.idex_rd1)));

    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        timeout_d   = timeout_q;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        exmem_hold  = 1'b0;

        // While reset is asserted the controls sit at their defaults even if
        // the pipeline is still presenting events.
        if (rst_n) begin
            case (state_q)
                ST_RUN, ST_LOAD_STALL, ST_FLUSH: begin
                    if (mem_stall) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        exmem_hold = 1'b1;
                        wait_cnt_d = 8'd0;
                        state_d    = ST_MEM_WAIT;
                    end else if (hs.br_taken) begin
                        // Also restarts an in-progress flush.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        state_d     = ST_FLUSH;
                    end else if (state_q == ST_FLUSH) begin
                        // Second flush cycle covers the wrong-path fetch
                        // still in flight; load-use is ignored here.
                        ifid_flush = 1'b1;
                        state_d    = ST_RUN;
                    end else if ((state_q == ST_RUN) && load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                        state_d     = ST_LOAD_STALL;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                ST_MEM_WAIT: begin
                    if (hs.mem_ack) begin
                        state_d = ST_RUN;
                    end else if (wait_cnt_q == 8'(MEM_TO)) begin
                        timeout_d = 1'b1;
                        state_d   = ST_RUN;
                    end else begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        exmem_hold = 1'b1;
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            wait_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign hs.pc_write    = pc_write;
    assign hs.ifid_write  = ifid_write;
    assign hs.idex_bubble = idex_bubble;
    assign hs.ifid_flush  = ifid_flush;
    assign hs.exmem_hold  = exmem_hold;
    assign hs.mem_timeout = timeout_q;
    assign dbg_state      = state_q;

`ifdef HAZ_STATS_EN
    logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [STAT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Saturating: stop at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (!pc_write && (stall_cnt_q != {STAT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (ifid_flush && (flush_cnt_q != {STAT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= {STAT_W{1'b0}};
            flush_cnt_q <= {STAT_W{1'b0}};
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hs.stall_cnt = stall_cnt_q;
    assign hs.flush_cnt = flush_cnt_q;
`else
    assign hs.stall_cnt = {STAT_W{1'b0}};
    assign hs.flush_cnt = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_stall_ctrl
// Directed vectors for hazard_stall_ctrl (MEM_TO = 15, STAT_W = 16).
// Each vector is applied 1 time unit after a rising edge; its hand-computed
// expected state/controls/timeout plus the expected statistics counters are
// pushed to exp_q. A monitor on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

    localparam int STAT_W = 16;
    localparam int W      = 2 + 6 + 2 * STAT_W;

    localparam logic [1:0] RUN = 2'd0;
    localparam logic [1:0] LDS = 2'd1;
    localparam logic [1:0] FLS = 2'd2;
    localparam logic [1:0] MWT = 2'd3;

    // {pc_write, ifid_write, idex_bubble, ifid_flush, exmem_hold}
    localparam logic [4:0] O_DEF   = 5'b11000;
    localparam logic [4:0] O_LU    = 5'b00100;
    localparam logic [4:0] O_BR    = 5'b11110;
    localparam logic [4:0] O_FL2   = 5'b11010;
    localparam logic [4:0] O_FRZ   = 5'b00001;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] dbg_state;

    always #5 clk = ~clk;

    hazard_stall_ctrl_if #(.STAT_W(STAT_W)) hs ();

    hazard_stall_ctrl #(.STAT_W(STAT_W), .MEM_TO(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hs        (hs),
        .dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    int           exp_stall = 0;
    int           exp_flush = 0;

    // ---------------- driver ----------------
    task automatic vec(input string nm, input bit rst,
                       input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                       input logic [2:0] vld, input bit mr, input logic [2:0] rd1,
                       input bit br, input bit req, input bit ack,
                       input logic [1:0] st, input logic [4:0] o, input bit to);
        logic [STAT_W-1:0] es, ef;
        @(posedge clk);
        #1;
        rst_n              = rst;
        hs.id_rs_a         = a;
        hs.id_rs_b         = b;
        hs.id_rs_c         = c;
        hs.id_src_vld      = vld;
        hs.idex_memread    = mr;
        hs.idex_rd1        = rd1;
        hs.br_taken        = br;
        hs.mem_req         = req;
        hs.mem_ack         = ack;
        if (!rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end
`ifdef HAZ_STATS_EN
        es = STAT_W'(exp_stall);
        ef = STAT_W'(exp_flush);
`else
        es = '0;
        ef = '0;
`endif
        exp_q.push_back({st, o, to, es, ef});
        name_q.push_back(nm);
        if (rst && !o[4]) exp_stall++;
        if (rst && o[1])  exp_flush++;
    endtask

    task automatic idle(input string nm, input logic [1:0] st, input logic [4:0] o, input bit to);
        vec(nm, 1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, st, o, to);
    endtask

    task automatic mem(input string nm, input bit br, input bit ack,
                       input logic [1:0] st, input logic [4:0] o, input bit to);
        vec(nm, 1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, br, 1'b1, ack, st, o, to);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] e, g;
        string        nm;
        if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            g  = {dbg_state, hs.pc_write, hs.ifid_write, hs.idex_bubble, hs.ifid_flush,
                  hs.exmem_hold, hs.mem_timeout, hs.stall_cnt, hs.flush_cnt};
            n_tests++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL %s: got st=%0d ctl=%b to=%b stall=%0d flush=%0d, want st=%0d ctl=%b to=%b stall=%0d flush=%0d",
                         nm, g[W-1 -: 2], g[W-3 -: 5], g[2*STAT_W], g[2*STAT_W-1 -: STAT_W], g[STAT_W-1:0],
                         e[W-1 -: 2], e[W-3 -: 5], e[2*STAT_W], e[2*STAT_W-1 -: STAT_W], e[STAT_W-1:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        hs.id_rs_a = '0; hs.id_rs_b = '0; hs.id_rs_c = '0; hs.id_src_vld = '0;
        hs.idex_memread = 1'b0; hs.idex_rd1 = '0;
        hs.br_taken = 1'b0; hs.mem_req = 1'b0; hs.mem_ack = 1'b0;

        // reset state, and controls stay at defaults while reset is held
        vec("reset_idle", 1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, RUN, O_DEF, 1'b0);
        vec("reset_req",  1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b1, 1'b1, 1'b0, RUN, O_DEF, 1'b0);
        idle("run_idle", RUN, O_DEF, 1'b0);

        // load-use on operand b, one stall cycle then masked
        vec("lu_b",      1'b1, 3'd0, 3'd3, 3'd0, 3'b010, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, RUN, O_LU, 1'b0);
        vec("lu_b_mask", 1'b1, 3'd0, 3'd3, 3'd0, 3'b010, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, LDS, O_DEF, 1'b0);
        idle("lu_b_after", RUN, O_DEF, 1'b0);
        // no hazard: invalid operands, only an invalid operand matching, not a load
        vec("lu_novld",  1'b1, 3'd0, 3'd3, 3'd0, 3'b000, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, RUN, O_DEF, 1'b0);
        vec("lu_a_inv",  1'b1, 3'd3, 3'd5, 3'd0, 3'b010, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, RUN, O_DEF, 1'b0);
        vec("lu_noload", 1'b1, 3'd3, 3'd3, 3'd3, 3'b111, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, RUN, O_DEF, 1'b0);
        // load-use on operand c
        vec("lu_c",      1'b1, 3'd0, 3'd0, 3'd6, 3'b100, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, RUN, O_LU, 1'b0);
        idle("lu_c_mask", LDS, O_DEF, 1'b0);

        // branch pulse: two flush cycles, bubble in the first
        vec("br_1",      1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, RUN, O_BR, 1'b0);
        idle("br_2", FLS, O_FL2, 1'b0);
        idle("br_done", RUN, O_DEF, 1'b0);
        // load-use suppressed in FLUSH, detected once back in RUN
        vec("brlu_1",    1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, RUN, O_BR, 1'b0);
        vec("brlu_fls",  1'b1, 3'd2, 3'd0, 3'd0, 3'b001, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, FLS, O_FL2, 1'b0);
        vec("brlu_run",  1'b1, 3'd2, 3'd0, 3'd0, 3'b001, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0, RUN, O_LU, 1'b0);
        idle("brlu_mask", LDS, O_DEF, 1'b0);
        // branch restarts FLUSH
        vec("brr_1",     1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, RUN, O_BR, 1'b0);
        vec("brr_2",     1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, FLS, O_BR, 1'b0);
        idle("brr_3", FLS, O_FL2, 1'b0);
        idle("brr_done", RUN, O_DEF, 1'b0);
        // branch beats load-use in RUN
        vec("br_vs_lu",  1'b1, 3'd1, 3'd0, 3'd0, 3'b001, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, RUN, O_BR, 1'b0);
        idle("br_vs_lu_2", FLS, O_FL2, 1'b0);
        // branch taken in LOAD_STALL
        vec("lsbr_lu",   1'b1, 3'd1, 3'd0, 3'd0, 3'b001, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, RUN, O_LU, 1'b0);
        vec("lsbr_br",   1'b1, 3'd1, 3'd0, 3'd0, 3'b001, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0, LDS, O_BR, 1'b0);
        idle("lsbr_2", FLS, O_FL2, 1'b0);
        idle("lsbr_done", RUN, O_DEF, 1'b0);

        // memory wait with ack after 4 cycles
        mem("mw_0", 1'b0, 1'b0, RUN, O_FRZ, 1'b0);
        for (int i = 0; i < 3; i++) mem("mw_hold", 1'b0, 1'b0, MWT, O_FRZ, 1'b0);
        mem("mw_ack", 1'b0, 1'b1, MWT, O_DEF, 1'b0);
        idle("mw_done", RUN, O_DEF, 1'b0);
        // request acked in the same cycle: no stall
        mem("mw_same", 1'b0, 1'b1, RUN, O_DEF, 1'b0);
        // memory wait beats load-use
        vec("mw_vs_lu",  1'b1, 3'd4, 3'd0, 3'd0, 3'b001, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0, RUN, O_FRZ, 1'b0);
        mem("mw_vs_lu_ack", 1'b0, 1'b1, MWT, O_DEF, 1'b0);
        // branch together with memory wait: wait first, flush after exit
        mem("mwbr_0", 1'b1, 1'b0, RUN, O_FRZ, 1'b0);
        mem("mwbr_ack", 1'b1, 1'b1, MWT, O_DEF, 1'b0);
        vec("mwbr_br",   1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, RUN, O_BR, 1'b0);
        idle("mwbr_fl2", FLS, O_FL2, 1'b0);

        // timeout: entry cycle + 15 held MEM_WAIT cycles, released on the 16th
        mem("to_0", 1'b0, 1'b0, RUN, O_FRZ, 1'b0);
        for (int i = 0; i < 15; i++) mem("to_hold", 1'b0, 1'b0, MWT, O_FRZ, 1'b0);
        mem("to_release", 1'b0, 1'b0, MWT, O_DEF, 1'b0);
        idle("to_sticky_1", RUN, O_DEF, 1'b1);
        idle("to_sticky_2", RUN, O_DEF, 1'b1);
        mem("to_sticky_acked", 1'b0, 1'b1, RUN, O_DEF, 1'b1);

        // asynchronous reset in the middle of MEM_WAIT
        mem("rmw_0", 1'b0, 1'b0, RUN, O_FRZ, 1'b1);
        mem("rmw_1", 1'b0, 1'b0, MWT, O_FRZ, 1'b1);
        vec("rmw_reset", 1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, RUN, O_DEF, 1'b0);
        idle("rmw_after", RUN, O_DEF, 1'b0);
        // asynchronous reset in the middle of FLUSH
        vec("rfl_br",    1'b1, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, RUN, O_BR, 1'b0);
        vec("rfl_reset", 1'b0, 3'd0, 3'd0, 3'd0, 3'b000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, RUN, O_DEF, 1'b0);
        idle("rfl_after", RUN, O_DEF, 1'b0);
        idle("rfl_after2", RUN, O_DEF, 1'b0);

        // drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
